// File: rtl/dataflow_carry_if.sv
// Handshake bundle for the loop-carried value selector: init, next and cond inputs plus the output stream.
// master drives the input tokens and out_ready; slave is the carry block.
interface dataflow_carry_if #(parameter int WIDTH = 32);
    logic             init_valid;
    logic             init_ready;
    logic [WIDTH-1:0] init_data;
    logic             next_valid;
    logic             next_ready;
    logic [WIDTH-1:0] next_data;
    logic             cond_valid;
    logic             cond_ready;
    logic             cond_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output init_valid, init_data, next_valid, next_data, cond_valid, cond_data, out_ready,
        input  init_ready, next_ready, cond_ready, out_valid, out_data
    );

    modport slave (
        input  init_valid, init_data, next_valid, next_data, cond_valid, cond_data, out_ready,
        output init_ready, next_ready, cond_ready, out_valid, out_data
    );
endinterface

// File: rtl/dataflow_carry.sv
// Loop-carried value selector: emits init, then one next token per cond=1, re-arms on cond=0.
// Latency 1 cycle through a single output register; full throughput with drain-and-load.
// Backpressure: init and cond=1 loads stall while the output is held; a cond=0 exit always drains.
module dataflow_carry #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dataflow_carry_if.slave bus
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_LOOP = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] load_data;
    logic             load;
    logic             slot_free;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        slot_free      = !out_valid_q || bus.out_ready;
        bus.init_ready = 1'b0;
        bus.next_ready = 1'b0;
        bus.cond_ready = 1'b0;
        state_d        = state_q;
        load           = 1'b0;
        load_data      = out_data_q;
        case (state_q)
            S_INIT: begin
                bus.init_ready = rst_n && slot_free;
                if (bus.init_valid && bus.init_ready) begin
                    load      = 1'b1;
                    load_data = bus.init_data;
                    state_d   = S_LOOP;
                end
            end
            S_LOOP: begin
                if (bus.cond_data) begin
                    // cond and next are consumed as a pair, never one alone.
                    bus.cond_ready = rst_n && bus.cond_valid && bus.next_valid && slot_free;
                    bus.next_ready = bus.cond_ready;
                    if (bus.cond_valid && bus.cond_ready) begin
                        load      = 1'b1;
                        load_data = bus.next_data;
                    end
                end else begin
                    bus.cond_ready = rst_n;
                    if (bus.cond_valid && bus.cond_ready) begin
                        state_d = S_INIT;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dataflow_carry.sv
// Bench for dataflow_carry: directed loop scenarios, then random loop instances
// scored against a token-level model (init followed by its K next values per instance).
module tb_dataflow_carry;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dataflow_carry_if #(.WIDTH(32)) bus ();

    dataflow_carry #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle just before the rising edge.
    task automatic cyc(input logic iv, input logic [31:0] id, input logic nv, input logic [31:0] nd,
                       input logic cv, input logic cd, input logic ordy);
        @(negedge clk);
        bus.init_valid = iv;
        bus.init_data  = id;
        bus.next_valid = nv;
        bus.next_data  = nd;
        bus.cond_valid = cv;
        bus.cond_data  = cd;
        bus.out_ready  = ordy;
        #4;
    endtask

    logic [31:0] init_q[$];
    logic [31:0] next_q[$];
    logic [31:0] exp_q[$];
    bit          cond_q[$];

    initial begin
        int   cycles;
        logic cf, nf, inf;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.init_valid = 1'b0; bus.init_data = '0;
        bus.next_valid = 1'b0; bus.next_data = '0;
        bus.cond_valid = 1'b0; bus.cond_data = 1'b0;
        bus.out_ready  = 1'b1;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_init_ready", bus.init_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // three-iteration loop with cond/next presented early while waiting for init
        cyc(1, 10, 1, 11, 1, 1, 1);
        check("s1_init_ready", bus.init_ready, 1);
        check("s5_cond_ready_early", bus.cond_ready, 0);
        check("s5_next_ready_early", bus.next_ready, 0);
        cyc(0, 0, 1, 11, 1, 1, 1);
        check("s1_out0", bus.out_data, 10);
        check("s1_out0_valid", bus.out_valid, 1);
        check("s1_pair_ready", {bus.cond_ready, bus.next_ready}, 2'b11);
        cyc(0, 0, 1, 12, 1, 1, 1);
        check("s1_out1", bus.out_data, 11);
        check("s1_next_ready", bus.next_ready, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s1_out2", bus.out_data, 12);
        check("s1_exit_ready", {bus.cond_ready, bus.next_ready}, 2'b10);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("s1_bubble", bus.out_valid, 0);
        check("s1_rearm", bus.init_ready, 1);

        // zero-iteration loop, then a second instance
        cyc(1, 7, 0, 0, 1, 0, 1);
        check("s2_init_ready", bus.init_ready, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s2_out", bus.out_data, 7);
        check("s2_exit_ready", {bus.cond_ready, bus.next_ready}, 2'b10);
        cyc(1, 8, 0, 0, 0, 0, 1);
        check("s2_bubble", bus.out_valid, 0);
        check("s2_rearm", bus.init_ready, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s2_out_second", {bus.out_valid, bus.out_data}, {1'b1, 32'd8});

        // back-pressure: held output blocks the cond=1 pair
        cyc(1, 30, 0, 0, 0, 0, 0);
        check("s3_init_ready", bus.init_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 5, 1, 1, 0);
            check("s3_blocked", {bus.cond_ready, bus.next_ready}, 2'b00);
            check("s3_hold", {bus.out_valid, bus.out_data}, {1'b1, 32'd30});
        end
        cyc(0, 0, 1, 5, 1, 1, 1);
        check("s3_release", {bus.cond_ready, bus.next_ready}, 2'b11);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s3_out", {bus.out_valid, bus.out_data}, {1'b1, 32'd5});

        // flag/data skew: cond waits for next
        cyc(1, 40, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 1);
        check("s4_out_init", bus.out_data, 40);
        check("s4_wait0", bus.cond_ready, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 1, 1, 1);
            check("s4_wait", {bus.cond_ready, bus.out_valid}, 2'b00);
        end
        cyc(0, 0, 1, 41, 1, 1, 1);
        check("s4_fire", {bus.cond_ready, bus.next_ready}, 2'b11);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s4_out", {bus.out_valid, bus.out_data}, {1'b1, 32'd41});

        // reset mid-loop discards the pending token
        cyc(1, 10, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("s6_pending", {bus.out_valid, bus.out_data}, {1'b1, 32'd10});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_clear", bus.out_valid, 0);
        check("s6_rst_ready", bus.init_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 20, 0, 0, 0, 0, 1);
        check("s6_rearm", bus.init_ready, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("s6_out", {bus.out_valid, bus.out_data}, {1'b1, 32'd20});
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("s6_idle", bus.out_valid, 0);

        // random loop instances: each yields init then its K next values
        for (int n = 0; n < 40; n++) begin
            int          k;
            logic [31:0] v;
            k = $urandom_range(0, 5);
            v = $urandom;
            init_q.push_back(v);
            exp_q.push_back(v);
            for (int j = 0; j < k; j++) begin
                v = $urandom;
                next_q.push_back(v);
                exp_q.push_back(v);
                cond_q.push_back(1'b1);
            end
            cond_q.push_back(1'b0);
        end

        cycles = 0;
        while ((exp_q.size() > 0 || cond_q.size() > 0) && cycles < 20000) begin
            cycles++;
            @(negedge clk);
            bus.init_valid = (init_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.init_data  = (init_q.size() > 0) ? init_q[0] : $urandom;
            bus.next_valid = (next_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.next_data  = (next_q.size() > 0) ? next_q[0] : $urandom;
            bus.cond_valid = (cond_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.cond_data  = (cond_q.size() > 0) ? cond_q[0] : 1'($urandom_range(0, 1));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            #4;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("rnd_extra_out", 1, 0);
                else                   check("rnd_out_tok", bus.out_data, exp_q.pop_front());
            end
            cf  = bus.cond_valid && bus.cond_ready;
            nf  = bus.next_valid && bus.next_ready;
            inf = bus.init_valid && bus.init_ready;
            if (cf || nf) check("rnd_cond_next_pair", {cf, nf}, {1'b1, bus.cond_data});
            if (cf)  void'(cond_q.pop_front());
            if (nf)  void'(next_q.pop_front());
            if (inf) void'(init_q.pop_front());
        end
        check("rnd_all_consumed", exp_q.size() + cond_q.size() + init_q.size() + next_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
